// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Holds one instruction, issues the data-SRAM
// request for loads and stores, waits for the response, aligns and extends
// load data, and presents the writeback value downstream. Also feeds
// forwarding and load-use stall information back to decode.
module mem_stage (
  input  logic        clk,
  input  logic        rst,

  // upstream handshake and instruction fields
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] rkd_value,
  input  logic [7:0]  mem_op,
  input  logic        res_from_mem,
  input  logic        mem_we,
  input  logic        gr_we,
  input  logic        has_exception,
  input  logic [4:0]  dest,

  // data bus
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,

  // downstream handshake and results
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] result_out,
  output logic        gr_we_out,
  output logic        has_exception_out,
  output logic [4:0]  dest_out,

  // forwarding to decode
  output logic        fwd_we,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_value,
  output logic        fwd_block
);

  // mem_op bit positions
  localparam int unsigned OpLdB  = 0;
  localparam int unsigned OpLdH  = 1;
  localparam int unsigned OpLdW  = 2;
  localparam int unsigned OpLdBu = 3;
  localparam int unsigned OpLdHu = 4;
  localparam int unsigned OpStB  = 5;
  localparam int unsigned OpStH  = 6;
  localparam int unsigned OpStW  = 7;

  localparam logic [31:0] ResetPc = 32'h1c00_0000;

  typedef enum logic [2:0] {
    StEmpty,
    StReq,
    StWait,
    StDone,
    StDiscard
  } state_e;

  state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] rkd_q;
  logic [31:0] result_q;
  logic [7:0]  op_q;
  logic        res_from_mem_q;
  logic        mem_we_q;
  logic        gr_we_q;
  logic        exc_q;
  logic [4:0]  dest_q;

  logic        in_fire;
  logic        out_fire;
  logic        capture_load;
  state_e      entry_state;
  logic [31:0] load_value;
  logic [31:0] shifted;

  // Handshake decode; flush suppresses both directions of transfer.
  always_comb begin
    in_ready  = (state_q == StEmpty) || ((state_q == StDone) && out_ready && !flush);
    out_valid = (state_q == StDone) && !flush;
    data_req  = (state_q == StReq) && !flush;
    in_fire   = in_valid && in_ready && !flush;
    out_fire  = out_valid && out_ready;
    // Faulting instructions never touch the bus; they go straight to DONE.
    entry_state = ((res_from_mem || mem_we) && !has_exception) ? StReq : StDone;
    capture_load = (state_q == StWait) && data_data_ok && !flush && res_from_mem_q;
  end

  // Next-state logic for the holding FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) state_d = entry_state;
      end
      StReq: begin
        if (flush) begin
          // An accepted address means a response is still on its way.
          state_d = data_addr_ok ? StDiscard : StEmpty;
        end else if (data_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush) begin
          // Response arriving in the flush cycle itself leaves nothing to drop.
          state_d = data_data_ok ? StEmpty : StDiscard;
        end else if (data_data_ok) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (flush) begin
          state_d = StEmpty;
        end else if (out_fire) begin
          state_d = in_fire ? entry_state : StEmpty;
        end
      end
      StDiscard: begin
        if (data_data_ok) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction field latch on input transfer; load data replaces the ALU value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= ResetPc;
      addr_q         <= '0;
      rkd_q          <= '0;
      result_q       <= '0;
      op_q           <= '0;
      res_from_mem_q <= 1'b0;
      mem_we_q       <= 1'b0;
      gr_we_q        <= 1'b0;
      exc_q          <= 1'b0;
      dest_q         <= '0;
    end else if (in_fire) begin
      pc_q           <= pc;
      addr_q         <= alu_result;
      rkd_q          <= rkd_value;
      result_q       <= alu_result;
      op_q           <= mem_op;
      res_from_mem_q <= res_from_mem;
      mem_we_q       <= mem_we;
      gr_we_q        <= gr_we;
      exc_q          <= has_exception;
      dest_q         <= dest;
    end else if (capture_load) begin
      result_q       <= load_value;
    end
  end

  // Load data alignment and sign/zero extension.
  always_comb begin
    shifted    = data_rdata >> {addr_q[1:0], 3'b000};
    load_value = data_rdata;
    if (op_q[OpLdB]) begin
      load_value = {{24{shifted[7]}}, shifted[7:0]};
    end else if (op_q[OpLdBu]) begin
      load_value = {24'b0, shifted[7:0]};
    end else if (op_q[OpLdH]) begin
      load_value = {{16{shifted[15]}}, shifted[15:0]};
    end else if (op_q[OpLdHu]) begin
      load_value = {16'b0, shifted[15:0]};
    end else if (op_q[OpLdW]) begin
      load_value = data_rdata;
    end
  end

  // Bus request encoding; derived only from held fields so it stays stable in REQ.
  always_comb begin
    data_size  = 2'd0;
    data_wstrb = 4'b0000;
    data_wdata = 32'b0;
    data_wr    = mem_we_q;
    data_addr  = addr_q;
    if (op_q[OpLdW] || op_q[OpStW]) begin
      data_size = 2'd2;
    end else if (op_q[OpLdH] || op_q[OpLdHu] || op_q[OpStH]) begin
      data_size = 2'd1;
    end
    if (op_q[OpStB]) begin
      data_wstrb = 4'b0001 << addr_q[1:0];
      data_wdata = {4{rkd_q[7:0]}};
    end else if (op_q[OpStH]) begin
      data_wstrb = 4'b0011 << {addr_q[1], 1'b0};
      data_wdata = {2{rkd_q[15:0]}};
    end else if (op_q[OpStW]) begin
      data_wstrb = 4'b1111;
      data_wdata = rkd_q;
    end
  end

  // Downstream and forwarding outputs.
  always_comb begin
    pc_out            = pc_q;
    result_out        = result_q;
    gr_we_out         = gr_we_q;
    has_exception_out = exc_q;
    dest_out          = dest_q;
    fwd_we            = (state_q != StEmpty) && (state_q != StDiscard) && gr_we_q &&
                        (dest_q != 5'd0);
    fwd_dest          = dest_q;
    fwd_value         = result_q;
    fwd_block         = res_from_mem_q && ((state_q == StReq) || (state_q == StWait));
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions checked against a behavioural load/store model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic [31:0] pc, alu_result, rkd_value;
  logic [7:0]  mem_op;
  logic        res_from_mem, mem_we, gr_we, has_exception;
  logic [4:0]  dest;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid, out_ready;
  logic [31:0] pc_out, result_out;
  logic        gr_we_out, has_exception_out;
  logic [4:0]  dest_out;
  logic        fwd_we;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_value;
  logic        fwd_block;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .pc(pc), .alu_result(alu_result), .rkd_value(rkd_value), .mem_op(mem_op),
    .res_from_mem(res_from_mem), .mem_we(mem_we), .gr_we(gr_we),
    .has_exception(has_exception), .dest(dest),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .result_out(result_out), .gr_we_out(gr_we_out),
    .has_exception_out(has_exception_out), .dest_out(dest_out),
    .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_value(fwd_value), .fwd_block(fwd_block)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc_got;
    logic [31:0] pc_exp;
    int          lat;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wr;
    bit          stable;
    bit          blk_all;
    bit          blk_any;
    bit          req_seen;
    bit          timed_out;
  } xact_t;

  // Op index: 0 ld.b, 1 ld.h, 2 ld.w, 3 ld.bu, 4 ld.hu, 5 st.b, 6 st.h, 7 st.w, 8 ALU.
  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    longint unsigned v, b, h;
    int unsigned a;
    a = addr % 4;
    v = rdata;
    b = (v / (64'd1 << (8 * a))) % 256;
    h = (v / (64'd1 << (8 * a))) % 65536;
    case (op)
      0: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      1: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3: return 32'(b);
      4: return 32'(h);
      default: return rdata;
    endcase
  endfunction

  // Expected bus request fields for a memory op.
  task automatic ref_bus(input int op, input logic [31:0] addr, input logic [31:0] rkd,
                         output logic [1:0] size, output logic [3:0] wstrb,
                         output logic [31:0] wdata, output logic wr);
    int unsigned a;
    a = addr % 4;
    wr = (op >= 5);
    wstrb = 4'b0000;
    wdata = 32'b0;
    if (op == 2 || op == 7) size = 2'd2;
    else if (op == 1 || op == 4 || op == 6) size = 2'd1;
    else size = 2'd0;
    if (op == 5) begin
      wstrb = 4'(1 << a);
      wdata = (rkd % 256) * 32'h0101_0101;
    end else if (op == 6) begin
      wstrb = (a >= 2) ? 4'b1100 : 4'b0011;
      wdata = (rkd % 65536) * 32'h0001_0001;
    end else if (op == 7) begin
      wstrb = 4'b1111;
      wdata = rkd;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 0;
    pc = 0; alu_result = 0; rkd_value = 0; mem_op = 0;
    res_from_mem = 0; mem_we = 0; gr_we = 0; has_exception = 0; dest = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic set_instr(input int op, input logic exc, input logic [31:0] addr,
                           input logic [31:0] rkd, input logic [31:0] ipc);
    pc = ipc; alu_result = addr; rkd_value = rkd;
    mem_op = (op < 8) ? 8'(1 << op) : 8'd0;
    res_from_mem = (op < 5);
    mem_we = (op >= 5 && op < 8);
    gr_we = (op < 5 || op == 8);
    has_exception = exc;
    dest = 5'($urandom_range(1, 31));
  endtask

  // Drives one instruction from an empty stage through to its output transfer,
  // servicing the bus with the given wait counts when the op is a clean memory op.
  task automatic xact(input int op, input logic exc, input logic [31:0] addr,
                      input logic [31:0] rkd, input logic [31:0] rdata,
                      input int aw, input int dw, output xact_t r);
    bit mem;
    int n;
    mem = (op < 8) && !exc;
    r.pc_exp = $urandom;
    r.stable = 1; r.blk_all = 1; r.blk_any = 0; r.req_seen = 0; r.timed_out = 0;
    r.size = 'x; r.wstrb = 'x; r.wdata = 'x; r.wr = 'x; r.res = 'x; r.pc_got = 'x;
    set_instr(op, exc, addr, rkd, r.pc_exp);
    in_valid = 1; out_ready = 0;
    cyc();
    in_valid = 0;
    r.lat = 1;
    if (mem) begin
      for (int k = 0; k <= aw; k++) begin
        data_addr_ok = (k == aw);
        #1;
        if (data_req) r.req_seen = 1;
        if (k == 0) begin
          r.size = data_size; r.wstrb = data_wstrb; r.wdata = data_wdata; r.wr = data_wr;
        end else if (data_size !== r.size || data_wstrb !== r.wstrb ||
                     data_wdata !== r.wdata || data_wr !== r.wr || data_addr !== addr ||
                     data_req !== 1'b1) begin
          r.stable = 0;
        end
        if (k == 0 && data_addr !== addr) r.stable = 0;
        r.blk_all &= fwd_block; r.blk_any |= fwd_block;
        cyc(); r.lat++;
      end
      data_addr_ok = 0;
      for (int k = 0; k <= dw; k++) begin
        data_data_ok = (k == dw);
        data_rdata = (k == dw) ? rdata : $urandom;
        #1;
        if (data_req) r.req_seen = 1;
        r.blk_all &= fwd_block; r.blk_any |= fwd_block;
        cyc(); r.lat++;
      end
      data_data_ok = 0;
    end
    #1;
    n = 0;
    while (!out_valid && n < 12) begin
      if (data_req) r.req_seen = 1;
      cyc(); #1; r.lat++; n++;
    end
    if (out_valid) begin
      r.res = result_out; r.pc_got = pc_out;
      out_ready = 1;
      cyc();
      out_ready = 0;
    end else begin
      r.timed_out = 1;
      rst = 1; cyc(); rst = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    tests_run++;
    if (in_ready !== 1 || out_valid !== 0 || data_req !== 0) begin
      tests_failed++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b data_req=%b want 1 0 0",
               in_ready, out_valid, data_req);
    end
    tests_run++;
    if (pc_out !== 32'h1c00_0000 || result_out !== 0 || fwd_value !== 0) begin
      tests_failed++;
      $display("FAIL reset_values: pc_out=%h result_out=%h fwd_value=%h want 1c000000 0 0",
               pc_out, result_out, fwd_value);
    end
    tests_run++;
    if (fwd_we !== 0 || fwd_block !== 0 || data_wstrb !== 0 || data_addr !== 0 ||
        gr_we_out !== 0 || dest_out !== 0 || has_exception_out !== 0 || data_wr !== 0) begin
      tests_failed++;
      $display("FAIL reset_misc: fwd_we=%b fwd_block=%b wstrb=%b addr=%h gr_we=%b dest=%0d",
               fwd_we, fwd_block, data_wstrb, data_addr, gr_we_out, dest_out);
    end
    rst = 0;
    // Reset must also abandon an instruction sitting in REQ.
    set_instr(2, 0, 32'h40, 0, 32'h1c00_0040);
    in_valid = 1; cyc(); in_valid = 0;
    #1;
    tests_run++;
    if (data_req !== 1) begin
      tests_failed++;
      $display("FAIL reset_pre_req: data_req=%b want 1", data_req);
    end
    rst = 1; cyc(); rst = 0; #1;
    tests_run++;
    if (data_req !== 0 || in_ready !== 1 || fwd_block !== 0) begin
      tests_failed++;
      $display("FAIL reset_midflight: data_req=%b in_ready=%b fwd_block=%b want 0 1 0",
               data_req, in_ready, fwd_block);
    end
    idle_inputs();
  endtask

  task automatic test_ld_w();
    xact_t r;
    xact(2, 0, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, r);
    tests_run++;
    if (r.res !== 32'hDEAD_BEEF || r.lat !== 3) begin
      tests_failed++;
      $display("FAIL ld_w: result=%h latency=%0d want deadbeef 3", r.res, r.lat);
    end
    tests_run++;
    if (r.size !== 2'd2 || r.wstrb !== 4'b0000 || r.wr !== 0 || r.pc_got !== r.pc_exp) begin
      tests_failed++;
      $display("FAIL ld_w_bus: size=%0d wstrb=%b wr=%b pc=%h want 2 0000 0 %h",
               r.size, r.wstrb, r.wr, r.pc_got, r.pc_exp);
    end
  endtask

  task automatic test_ld_b();
    xact_t r;
    xact(0, 0, 32'h103, 0, 32'h8011_2233, 0, 0, r);
    tests_run++;
    if (r.res !== 32'hFFFF_FF80) begin
      tests_failed++;
      $display("FAIL ld_b: result=%h want ffffff80", r.res);
    end
    xact(3, 0, 32'h103, 0, 32'h8011_2233, 0, 0, r);
    tests_run++;
    if (r.res !== 32'h0000_0080 || r.size !== 2'd0) begin
      tests_failed++;
      $display("FAIL ld_bu: result=%h size=%0d want 00000080 0", r.res, r.size);
    end
  endtask

  task automatic test_st_h();
    xact_t r;
    xact(6, 0, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, r);
    tests_run++;
    if (r.wstrb !== 4'b1100 || r.wdata !== 32'hABCD_ABCD || r.wr !== 1 || r.size !== 2'd1) begin
      tests_failed++;
      $display("FAIL st_h: wstrb=%b wdata=%h wr=%b size=%0d want 1100 abcdabcd 1 1",
               r.wstrb, r.wdata, r.wr, r.size);
    end
  endtask

  task automatic test_flush();
    set_instr(2, 0, 32'h300, 0, 32'h1c00_0300);
    in_valid = 1; cyc(); in_valid = 0;
    data_addr_ok = 1; cyc(); data_addr_ok = 0;
    flush = 1; #1;
    tests_run++;
    if (out_valid !== 0 || in_ready !== 0 || data_req !== 0) begin
      tests_failed++;
      $display("FAIL flush_wait: out_valid=%b in_ready=%b data_req=%b want 0 0 0",
               out_valid, in_ready, data_req);
    end
    cyc(); flush = 0; #1;
    tests_run++;
    if (in_ready !== 0 || out_valid !== 0 || fwd_we !== 0 || fwd_block !== 0) begin
      tests_failed++;
      $display("FAIL flush_discard: in_ready=%b out_valid=%b fwd_we=%b fwd_block=%b want 0 0 0 0",
               in_ready, out_valid, fwd_we, fwd_block);
    end
    cyc();
    data_data_ok = 1; data_rdata = 32'h1234_5678; #1;
    tests_run++;
    if (in_ready !== 0 || out_valid !== 0) begin
      tests_failed++;
      $display("FAIL flush_drop: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    cyc(); data_data_ok = 0; #1;
    tests_run++;
    if (in_ready !== 1 || out_valid !== 0) begin
      tests_failed++;
      $display("FAIL flush_empty: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    // Flush in REQ without address acceptance returns straight to EMPTY.
    set_instr(1, 0, 32'h310, 0, 32'h1c00_0310);
    in_valid = 1; cyc(); in_valid = 0;
    flush = 1; #1;
    tests_run++;
    if (data_req !== 0) begin
      tests_failed++;
      $display("FAIL flush_req_gate: data_req=%b want 0", data_req);
    end
    cyc(); flush = 0; #1;
    tests_run++;
    if (in_ready !== 1 || data_req !== 0) begin
      tests_failed++;
      $display("FAIL flush_req: in_ready=%b data_req=%b want 1 0", in_ready, data_req);
    end
    // Flush in DONE kills the held result.
    set_instr(8, 0, 32'h55, 0, 32'h1c00_0320);
    in_valid = 1; cyc(); in_valid = 0;
    flush = 1; out_ready = 1; #1;
    tests_run++;
    if (out_valid !== 0 || in_ready !== 0) begin
      tests_failed++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    cyc(); flush = 0; out_ready = 0; #1;
    tests_run++;
    if (out_valid !== 0 || in_ready !== 1) begin
      tests_failed++;
      $display("FAIL flush_done_after: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    idle_inputs();
  endtask

  task automatic test_addr_stall();
    xact_t r;
    xact(2, 0, 32'h400, 0, 32'hCAFE_F00D, 4, 1, r);
    tests_run++;
    if (r.stable !== 1 || r.blk_all !== 1 || r.req_seen !== 1) begin
      tests_failed++;
      $display("FAIL addr_stall: stable=%b fwd_block_all=%b req_seen=%b want 1 1 1",
               r.stable, r.blk_all, r.req_seen);
    end
    tests_run++;
    if (r.lat !== 8 || r.res !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL addr_stall_lat: latency=%0d result=%h want 8 cafef00d", r.lat, r.res);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [5];
    int valid_cycles;
    bit req_seen;
    valid_cycles = 0; req_seen = 0;
    for (int k = 0; k < 5; k++) vals[k] = $urandom;
    out_ready = 1;
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        set_instr(8, 0, vals[k], 0, 32'h1c00_1000 + 32'(4 * k));
        gr_we = 1; dest = 5'(k + 1);
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      #1;
      if (data_req) req_seen = 1;
      if (out_valid) valid_cycles++;
      if (k > 0) begin
        tests_run++;
        if (out_valid !== 1 || result_out !== vals[k-1] || fwd_we !== 1 ||
            fwd_value !== vals[k-1] || fwd_dest !== 5'(k)) begin
          tests_failed++;
          $display("FAIL b2b_%0d: out_valid=%b result=%h fwd_we=%b fwd_value=%h fwd_dest=%0d want 1 %h 1 %h %0d",
                   k, out_valid, result_out, fwd_we, fwd_value, fwd_dest, vals[k-1],
                   vals[k-1], k);
        end
      end
      if (k < 5) begin
        tests_run++;
        if (in_ready !== 1) begin
          tests_failed++;
          $display("FAIL b2b_ready_%0d: in_ready=%b want 1", k, in_ready);
        end
      end
      cyc();
    end
    #1;
    if (out_valid) valid_cycles++;
    tests_run++;
    if (valid_cycles !== 5 || req_seen !== 0) begin
      tests_failed++;
      $display("FAIL b2b_count: valid_cycles=%0d data_req_seen=%b want 5 0",
               valid_cycles, req_seen);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    xact_t r;
    int op, aw, dw;
    logic exc;
    logic [31:0] addr, rkd, rdata, exp_wdata;
    logic [1:0] exp_size;
    logic [3:0] exp_wstrb;
    logic exp_wr;
    int exp_lat;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 8);
      exc = ($urandom_range(0, 7) == 0);
      addr = $urandom;
      if (op == 2 || op == 7) addr[1:0] = 2'b00;
      else if (op == 1 || op == 4 || op == 6) addr[0] = 1'b0;
      rkd = $urandom; rdata = $urandom;
      aw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      xact(op, exc, addr, rkd, rdata, aw, dw, r);
      exp_lat = (op < 8 && !exc) ? 3 + aw + dw : 1;
      tests_run++;
      if (r.timed_out || r.lat !== exp_lat || r.pc_got !== r.pc_exp) begin
        tests_failed++;
        $display("FAIL rand_%0d_timing: op=%0d exc=%b latency=%0d pc=%h want %0d %h",
                 i, op, exc, r.lat, r.pc_got, exp_lat, r.pc_exp);
      end
      if (op < 5 && !exc) begin
        tests_run++;
        if (r.res !== ref_load(op, addr, rdata)) begin
          tests_failed++;
          $display("FAIL rand_%0d_load: op=%0d addr=%h rdata=%h result=%h want %h",
                   i, op, addr, rdata, r.res, ref_load(op, addr, rdata));
        end
      end else if (op == 8 || exc) begin
        tests_run++;
        if (r.res !== addr || r.req_seen !== 0) begin
          tests_failed++;
          $display("FAIL rand_%0d_alu: op=%0d result=%h data_req_seen=%b want %h 0",
                   i, op, r.res, r.req_seen, addr);
        end
      end
      if (op < 8 && !exc) begin
        ref_bus(op, addr, rkd, exp_size, exp_wstrb, exp_wdata, exp_wr);
        tests_run++;
        if (r.size !== exp_size || r.wstrb !== exp_wstrb || r.wr !== exp_wr ||
            (op >= 5 && r.wdata !== exp_wdata) || r.stable !== 1 || r.req_seen !== 1) begin
          tests_failed++;
          $display("FAIL rand_%0d_bus: op=%0d addr=%h size=%0d wstrb=%b wdata=%h wr=%b stable=%b want %0d %b %h %b 1",
                   i, op, addr, r.size, r.wstrb, r.wdata, r.wr, r.stable, exp_size,
                   exp_wstrb, exp_wdata, exp_wr);
        end
        tests_run++;
        if ((op < 5 && r.blk_all !== 1) || (op >= 5 && r.blk_any !== 0)) begin
          tests_failed++;
          $display("FAIL rand_%0d_fwd_block: op=%0d all=%b any=%b want %b",
                   i, op, r.blk_all, r.blk_any, (op < 5));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_ld_w();
    test_ld_b();
    test_st_h();
    test_flush();
    test_addr_stall();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage sitting directly after EX: it latches one instruction per handshake, issues the data-SRAM request for loads and stores, waits for the response, and produces the final writeback value for the next stage. Load results are byte/halfword aligned and sign- or zero-extended here. The stage also drives forwarding and load-use stall information back to decode.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid / in_ready  in / out  1  upstream handshake; transfer when both are high
- out_valid / out_ready  out / in  1  downstream handshake; transfer when both are high
- flush  in  1  flush from commit (exception, ertn, refetch); kills the held instruction
- pc, alu_result, rkd_value  in  32 each  instruction PC, effective address or ALU result, store data
- mem_op  in  8  one-hot: [0] ld.b, [1] ld.h, [2] ld.w, [3] ld.bu, [4] ld.hu, [5] st.b, [6] st.h, [7] st.w
- res_from_mem, mem_we, gr_we, has_exception  in  1 each
- dest  in  5  destination GPR
- data_req, data_wr  out  1 each  bus request; 1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_wstrb  out  4  byte enables
- data_addr, data_wdata  out  32 each
- data_addr_ok, data_data_ok  in  1 each  address accepted / response returned
- data_rdata  in  32
- pc_out, result_out  out  32 each  held PC and writeback value
- gr_we_out, has_exception_out  out  1 each
- dest_out  out  5
- fwd_we  out  1  held instruction will write `fwd_dest`
- fwd_dest  out  5
- fwd_value  out  32  value to forward
- fwd_block  out  1  held load has no data yet; decode must stall

## Operation
- Fields are latched on an input transfer.
- States:
  - EMPTY: nothing held.
  - REQ: request pending.
  - WAIT: address accepted, data outstanding.
  - DONE: result ready.
  - DISCARD: flushed while a response is still outstanding.
- The next state after an input transfer depends on the instruction:
  - Memory op (`res_from_mem` or `mem_we`) without `has_exception` goes to REQ.
  - Anything else goes to DONE with `result_out` = `alu_result`.
- REQ:
  - `data_req` = 1 while in REQ and `flush` = 0.
  - `data_addr_ok` = 1 moves the stage to WAIT.
  - A request that has not yet been accepted may be withdrawn.
- WAIT: `data_data_ok` = 1 captures the result and moves to DONE. Stores capture nothing useful; `gr_we` is 0 for stores.
- DONE:
  - `out_valid` = 1 only in DONE, and only while `flush` = 0.
  - On output transfer, go to REQ or DONE if a new input transfers in the same cycle, else EMPTY.
- `in_ready` = EMPTY, or (DONE and `out_ready` and not `flush`). It is 0 in REQ, WAIT and DISCARD.
- Flush:
  - EMPTY, DONE, or REQ without `data_addr_ok` that cycle go to EMPTY.
  - WAIT, or REQ with `data_addr_ok` that cycle, go to DISCARD.
  - DISCARD waits for `data_data_ok`, drops that data, then goes to EMPTY.
  - `flush` takes priority over any handshake in the same cycle.
- Store encoding, with a = address[1:0]:
  - st.b: size 0, `wstrb` = 4'b0001 << a, `wdata` = the byte replicated four times.
  - st.h: size 1, `wstrb` = 4'b0011 << {a[1],1'b0}, `wdata` = the halfword replicated twice.
  - st.w: size 2, `wstrb` = 4'b1111, `wdata` = `rkd_value`.
  - `data_wr` = `mem_we`.
- Load request: `data_wstrb` = 0. Size is 0 for ld.b/ld.bu, 1 for ld.h/ld.hu, 2 for ld.w.
- Load alignment: shifted = `data_rdata` >> (8·a).
  - ld.b / ld.bu: sign- / zero-extend shifted[7:0].
  - ld.h / ld.hu: sign- / zero-extend shifted[15:0].
  - ld.w: `data_rdata` unchanged.
- Forwarding:
  - `fwd_we` = state ∉ {EMPTY, DISCARD} and `gr_we` and `dest` ≠ 0.
  - `fwd_value` = `result_out`.
  - `fwd_block` = `res_from_mem` and state ∈ {REQ, WAIT}.
- Address alignment is checked upstream. An instruction arriving with `has_exception` never reaches the bus.

## Timing
- Reset values:
  - state EMPTY, `in_ready` 1, `out_valid` 0, `data_req` 0.
  - `pc_out` 32'h1c000000.
  - All other outputs 0.
- Non-memory instruction accepted at cycle t gives `out_valid` at t+1. Back-to-back throughput is one per cycle.
- Load accepted at t:
  - `data_req` at t+1.
  - With `data_addr_ok` at t+1 and `data_data_ok` at t+2, `out_valid` is at t+3.
  - Each extra bus wait cycle adds one cycle.
- Bus outputs are stable from the first `data_req` cycle until `data_addr_ok`.
- At most one outstanding request at a time.

## Test plan
- ld.w at 0x100, `addr_ok` and `data_ok` immediate, rdata 0xDEADBEEF -> `result_out` 0xDEADBEEF, `out_valid` 3 cycles after accept.
- ld.b at 0x103, rdata 0x80112233 -> `result_out` 0xFFFFFF80. ld.bu at the same address -> 0x00000080.
- st.h at 0x202, `rkd_value` 0x0000ABCD -> `data_wstrb` 4'b1100, `data_wdata` 0xABCDABCD, `data_wr` 1.
- ld.w with `flush` in WAIT, then `data_data_ok` 2 cycles later -> DISCARD, no `out_valid`, `in_ready` 0 until `data_ok`, then EMPTY.
- `data_addr_ok` held low for 4 cycles -> `data_req`, `data_addr` and `data_size` stable, `fwd_block` 1 throughout.
- 5 back-to-back ALU ops with `out_ready` = 1 -> 5 consecutive `out_valid` cycles, `data_req` never asserted.
